// File: rtl/pueo_command_encoder.sv
// TURF-side SURF command word builder: merges run commands, mode1 bytes
// and trigger times into one 32-bit word per command slot.
module pueo_command_encoder #(
    parameter int CMD_PERIOD      = 8,
    parameter int TRIG_FIFO_DEPTH = 4
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rstn_i,
    input  logic        enable_i,
    input  logic [1:0]  runcmd_i,
    input  logic        runcmd_valid_i,
    output logic        runcmd_ready_o,
    input  logic        cmdproc_rst_i,
    input  logic [1:0]  fw_mark_i,
    input  logic        notch_wr_i,
    input  logic [5:0]  notch0_byp_i,
    input  logic [5:0]  notch1_byp_i,
    output logic        notch_busy_o,
    input  logic [7:0]  fw_tdata,
    input  logic        fw_tvalid,
    output logic        fw_tready,
    input  logic [7:0]  cmdproc_tdata,
    input  logic        cmdproc_tvalid,
    input  logic        cmdproc_tlast,
    output logic        cmdproc_tready,
    input  logic [14:0] trig_time_i,
    input  logic        trig_valid_i,
    output logic        trig_overflow_o,
    output logic [31:0] command_o,
    output logic        command_valid_o
);

    localparam int PW = $clog2(CMD_PERIOD);
    localparam int AW = $clog2(TRIG_FIFO_DEPTH);

    typedef enum logic [1:0] {
        N_IDLE,
        N_N0,
        N_N1,
        N_UPD
    } notch_t;

    logic [PW-1:0] phase;
    logic          build;
    logic          send;
    logic          alive;

    logic          run_pend;
    logic [1:0]    run_q;
    logic          run_take;

    logic          rst_f, mark_a, mark_b;
    logic          clr_rst, clr_a, clr_b;

    notch_t        notch_s, notch_n;
    logic          notch_latch;
    logic [5:0]    mask0, mask1;

    logic [14:0]   mem [TRIG_FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    logic [15:0]   trig_field;

    logic [1:0]    m1_type;
    logic [7:0]    m1_data;
    logic [31:0]   next_word;

    assign build = (phase == PW'(CMD_PERIOD - 1));
    assign send  = build & enable_i;

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            phase <= '0;
            alive <= 1'b0;
        end else begin
            phase <= build ? '0 : phase + PW'(1);
            alive <= 1'b1;
        end
    end

    assign runcmd_ready_o = alive & ~run_pend;
    assign run_take       = runcmd_valid_i & runcmd_ready_o;

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            run_pend <= 1'b0;
            run_q    <= 2'b00;
        end else if (run_take) begin
            run_pend <= 1'b1;
            run_q    <= runcmd_i;
        end else if (send) begin
            run_pend <= 1'b0;
        end
    end

    // A request arriving while its flag is already set merges into it.
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            rst_f  <= 1'b0;
            mark_a <= 1'b0;
            mark_b <= 1'b0;
        end else begin
            rst_f  <= rst_f  ? ~clr_rst : cmdproc_rst_i;
            mark_a <= mark_a ? ~clr_a   : fw_mark_i[0];
            mark_b <= mark_b ? ~clr_b   : fw_mark_i[1];
        end
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            notch_s <= N_IDLE;
            mask0   <= 6'h3F;
            mask1   <= 6'h3F;
        end else begin
            notch_s <= notch_n;
            if (notch_latch) begin
                mask0 <= notch0_byp_i;
                mask1 <= notch1_byp_i;
            end
        end
    end

    assign notch_busy_o = (notch_s != N_IDLE);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = build & ~empty;
    assign push  = trig_valid_i & (~full | pop);

    always_ff @(posedge sysclk_i) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= trig_time_i;
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            trig_overflow_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            trig_overflow_o <= trig_valid_i & full & ~pop;
        end
    end

    assign trig_field = empty ? 16'h0000 :
                        {1'b1, mem[rd_ptr[AW-1:0]]};

    // Mode1 source selection, in strict priority order.
    always_comb begin
        notch_n        = notch_s;
        notch_latch    = 1'b0;
        m1_type        = 2'b00;
        m1_data        = 8'h00;
        clr_rst        = 1'b0;
        clr_a          = 1'b0;
        clr_b          = 1'b0;
        fw_tready      = 1'b0;
        cmdproc_tready = 1'b0;
        if (notch_s == N_IDLE && notch_wr_i) begin
            notch_n     = N_N0;
            notch_latch = 1'b1;
        end
        if (enable_i) begin
            if (rst_f) begin
                m1_data = 8'h01;
                clr_rst = build;
            end else if (notch_s != N_IDLE) begin
                case (notch_s)
                    N_N0: begin
                        m1_data = {2'b11, mask0};
                        if (build) notch_n = N_N1;
                    end
                    N_N1: begin
                        m1_data = {2'b10, mask1};
                        if (build) notch_n = N_UPD;
                    end
                    default: begin
                        m1_data = 8'h04;
                        if (build) notch_n = N_IDLE;
                    end
                endcase
            end else if (mark_a) begin
                m1_data = 8'h02;
                clr_a   = build;
            end else if (mark_b) begin
                m1_data = 8'h03;
                clr_b   = build;
            end else if (fw_tvalid) begin
                m1_type   = 2'b11;
                m1_data   = fw_tdata;
                fw_tready = build;
            end else if (cmdproc_tvalid) begin
                m1_type        = cmdproc_tlast ? 2'b11 : 2'b01;
                m1_data        = cmdproc_tdata;
                cmdproc_tready = build;
            end
        end
    end

    assign next_word = enable_i ?
        {4'b0000, (run_pend ? run_q : 2'b00), m1_type, m1_data, trig_field} :
        {1'b1, 15'h0000, trig_field};

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            command_o       <= 32'h8000_0000;
            command_valid_o <= 1'b0;
        end else begin
            command_valid_o <= build;
            if (build)
                command_o <= next_word;
        end
    end

endmodule

// File: tb/tb_pueo_command_encoder.sv
// Scoreboard bench for pueo_command_encoder: expected words are queued
// per slot and a monitor compares every presented command word.
module tb_pueo_command_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  runcmd;
    logic        runcmd_valid;
    logic        runcmd_ready;
    logic        cmdproc_rst;
    logic [1:0]  fw_mark;
    logic        notch_wr;
    logic [5:0]  notch0_byp, notch1_byp;
    logic        notch_busy;
    logic [7:0]  fw_tdata;
    logic        fw_tvalid, fw_tready;
    logic [7:0]  cp_tdata;
    logic        cp_tvalid, cp_tlast, cp_tready;
    logic [14:0] trig_time;
    logic        trig_valid, trig_overflow;
    logic [31:0] command;
    logic        command_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [2:0]  ph;

    always #5 clk = ~clk;

    pueo_command_encoder dut (
        .sysclk_i        (clk),
        .sysclk_rstn_i   (rst_n),
        .enable_i        (enable),
        .runcmd_i        (runcmd),
        .runcmd_valid_i  (runcmd_valid),
        .runcmd_ready_o  (runcmd_ready),
        .cmdproc_rst_i   (cmdproc_rst),
        .fw_mark_i       (fw_mark),
        .notch_wr_i      (notch_wr),
        .notch0_byp_i    (notch0_byp),
        .notch1_byp_i    (notch1_byp),
        .notch_busy_o    (notch_busy),
        .fw_tdata        (fw_tdata),
        .fw_tvalid       (fw_tvalid),
        .fw_tready       (fw_tready),
        .cmdproc_tdata   (cp_tdata),
        .cmdproc_tvalid  (cp_tvalid),
        .cmdproc_tlast   (cp_tlast),
        .cmdproc_tready  (cp_tready),
        .trig_time_i     (trig_time),
        .trig_valid_i    (trig_valid),
        .trig_overflow_o (trig_overflow),
        .command_o       (command),
        .command_valid_o (command_valid)
    );

    // Slot phase as the bench expects it: 0..7 free-running after reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= 3'd0;
        else        ph <= ph + 3'd1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && command_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", command);
            end else begin
                chk("word", command, exp_q.pop_front());
            end
        end
    end

    task automatic goto_build();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ph != 3'd7 && k < 16);
        if (ph != 3'd7) begin
            n_tests++;
            n_fail++;
            $display("FAIL build_timeout: got phase %0d expected 7", ph);
        end
    endtask

    task automatic slot(input logic [31:0] w, input logic fw_rdy,
                        input logic cp_rdy);
        exp_q.push_back(w);
        goto_build();
        chk("fw_tready", 32'(fw_tready), 32'(fw_rdy));
        chk("cmdproc_tready", 32'(cp_tready), 32'(cp_rdy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        runcmd = 2'd0;
        runcmd_valid = 1'b0;
        cmdproc_rst = 1'b0;
        fw_mark = 2'b00;
        notch_wr = 1'b0;
        notch0_byp = 6'h00;
        notch1_byp = 6'h00;
        fw_tdata = 8'h00;
        fw_tvalid = 1'b0;
        cp_tdata = 8'h00;
        cp_tvalid = 1'b0;
        cp_tlast = 1'b0;
        trig_time = 15'h0;
        trig_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_command", command, 32'h8000_0000);
        chk("rst_valid", 32'(command_valid), 32'd0);
        chk("rst_runcmd_ready", 32'(runcmd_ready), 32'd0);
        chk("rst_notch_busy", 32'(notch_busy), 32'd0);
        chk("rst_overflow", 32'(trig_overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("runcmd_ready_after_rst", 32'(runcmd_ready), 32'd1);

        // idle words
        slot(32'h0000_0000, 1'b0, 1'b0);
        slot(32'h0000_0000, 1'b0, 1'b0);

        // run command with cmdproc bytes
        runcmd = 2'd1;
        runcmd_valid = 1'b1;
        cp_tdata = 8'hA5;
        cp_tvalid = 1'b1;
        @(posedge clk);
        #1;
        runcmd_valid = 1'b0;
        chk("runcmd_pending", 32'(runcmd_ready), 32'd0);
        slot(32'h05A5_0000, 1'b0, 1'b1);
        cp_tdata = 8'h5A;
        cp_tlast = 1'b1;
        chk("runcmd_ready_again", 32'(runcmd_ready), 32'd1);
        slot(32'h035A_0000, 1'b0, 1'b1);
        cp_tvalid = 1'b0;
        cp_tlast = 1'b0;
        slot(32'h0000_0000, 1'b0, 1'b0);

        // notch sequence ahead of a pending firmware byte
        notch0_byp = 6'h15;
        notch1_byp = 6'h2A;
        notch_wr = 1'b1;
        fw_tdata = 8'h33;
        fw_tvalid = 1'b1;
        @(posedge clk);
        #1;
        notch_wr = 1'b0;
        notch0_byp = 6'h00;
        notch1_byp = 6'h00;
        chk("notch_busy_set", 32'(notch_busy), 32'd1);
        slot(32'h00D5_0000, 1'b0, 1'b0);
        slot(32'h00AA_0000, 1'b0, 1'b0);
        slot(32'h0004_0000, 1'b0, 1'b0);
        chk("notch_busy_clear", 32'(notch_busy), 32'd0);
        slot(32'h0333_0000, 1'b1, 1'b0);
        fw_tvalid = 1'b0;
        slot(32'h0000_0000, 1'b0, 1'b0);

        // five triggers into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            trig_time = 15'(i);
            trig_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        trig_valid = 1'b0;
        chk("overflow_pulse", 32'(trig_overflow), 32'd1);
        @(posedge clk);
        #1;
        chk("overflow_clear", 32'(trig_overflow), 32'd0);
        for (int i = 1; i <= 4; i++)
            slot(32'h0000_8000 | 32'(i), 1'b0, 1'b0);
        slot(32'h0000_0000, 1'b0, 1'b0);

        // simultaneous special requests
        cmdproc_rst = 1'b1;
        fw_mark = 2'b11;
        @(posedge clk);
        #1;
        cmdproc_rst = 1'b0;
        fw_mark = 2'b00;
        slot(32'h0001_0000, 1'b0, 1'b0);
        slot(32'h0002_0000, 1'b0, 1'b0);
        slot(32'h0003_0000, 1'b0, 1'b0);
        slot(32'h0000_0000, 1'b0, 1'b0);

        // disabled slot: trigger only, runcmd and fw byte held
        enable = 1'b0;
        runcmd = 2'd3;
        runcmd_valid = 1'b1;
        trig_time = 15'h7FFF;
        trig_valid = 1'b1;
        fw_tdata = 8'h44;
        fw_tvalid = 1'b1;
        @(posedge clk);
        #1;
        runcmd_valid = 1'b0;
        trig_valid = 1'b0;
        slot(32'h8000_FFFF, 1'b0, 1'b0);
        enable = 1'b1;
        chk("runcmd_held", 32'(runcmd_ready), 32'd0);
        slot(32'h0F44_0000, 1'b1, 1'b0);
        fw_tvalid = 1'b0;
        chk("runcmd_sent", 32'(runcmd_ready), 32'd1);
        slot(32'h0000_0000, 1'b0, 1'b0);

        // reset in the middle of a notch sequence
        notch0_byp = 6'h15;
        notch1_byp = 6'h2A;
        notch_wr = 1'b1;
        @(posedge clk);
        #1;
        notch_wr = 1'b0;
        slot(32'h00D5_0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_command", command, 32'h8000_0000);
        chk("midrst_valid", 32'(command_valid), 32'd0);
        chk("midrst_notch_busy", 32'(notch_busy), 32'd0);
        chk("midrst_runcmd_ready", 32'(runcmd_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_notch_busy", 32'(notch_busy), 32'd0);
        slot(32'h0000_0000, 1'b0, 1'b0);
        slot(32'h0000_0000, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
